// File: rtl/mux_pkg.sv
// Purpose: shared arbitration-mode type and width helper for the arbitrated mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_pkg;

    // Arbitration policy selector for rr_arbiter / rr_arb_mux
    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } arb_mode_e;

    // Width of a channel index; never below 1 so ports stay legal
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: one-hot grant among NCH requesters, round-robin from a pointer or fixed lowest-index.
// Latency: grant is combinational from req; pointer moves at the edge after an accepted grant.
// Backpressure: pointer holds unless advance is asserted, so a stalled grant is re-offered.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int        NCH  = 4,
    parameter arb_mode_e MODE = MODE_RR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           req,
    input  logic                     advance,
    output logic [NCH-1:0]           grant,
    output logic [idx_w(NCH)-1:0]    grant_idx
);

    localparam int IW = idx_w(NCH);

    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] start;

    // Fixed priority is a round-robin search that always starts at channel 0
    assign start = (MODE == MODE_FIXED) ? '0 : ptr;

    // First requester found scanning upward from start, wrapping NCH-1 -> 0
    always_comb begin
        logic          found;
        int            pos;
        logic [IW-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            pos = int'(start) + k;
            if (pos >= NCH) begin
                pos = pos - NCH;
            end
            cand = IW'(pos);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next pointer sits just past the winner so it becomes lowest priority
    always_comb begin
        int nxt;
        nxt = int'(grant_idx) + 1;
        if (nxt >= NCH) begin
            nxt = 0;
        end
        ptr_nxt = IW'(nxt);
    end

    // Pointer only moves on an accepted transfer, and only in round-robin mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (MODE == MODE_RR && advance) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Purpose: arbitrate NCH valid/ready channels into one registered output stream.
// Latency: 1 cycle from input transfer to out_valid; one beat per cycle sustained.
// Backpressure: out_valid && !out_ready freezes the output register and drops all in_ready.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter int        NCH  = 4,
    parameter int        W    = 8,
    parameter arb_mode_e MODE = MODE_RR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*W-1:0]         in_data,
    output logic [NCH-1:0]           in_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(NCH)-1:0]   out_sel,
    input  logic                     out_ready
);

    localparam int IW = idx_w(NCH);

    logic [NCH-1:0] grant;
    logic [IW-1:0]  grant_idx;
    logic           load;
    logic           in_xfer;
    logic [W-1:0]   sel_data;

    // Register is free when empty or being drained this cycle
    assign load     = !out_valid || out_ready;
    // rst_n gate keeps sources from seeing an accept while the block is held in reset
    assign in_ready = grant & {NCH{load & rst_n}};
    assign in_xfer  = |in_ready;

    rr_arbiter #(
        .NCH  (NCH),
        .MODE (MODE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (in_xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // One-hot data select driven by the grant vector
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_data = in_data[i*W +: W];
            end
        end
    end

    // Output register: reload on input transfer, else clear valid on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;
    import mux_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rr_valid;
    logic [3:0]  fx_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic [3:0]  rr_in_ready;
    logic        rr_out_valid;
    logic [7:0]  rr_out_data;
    logic [1:0]  rr_out_sel;

    logic [3:0]  fx_in_ready;
    logic        fx_out_valid;
    logic [7:0]  fx_out_data;
    logic [1:0]  fx_out_sel;

    int checks;
    int failures;

    rr_arb_mux #(.NCH(4), .W(8), .MODE(MODE_RR)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rr_valid),
        .in_data   (in_data),
        .in_ready  (rr_in_ready),
        .out_valid (rr_out_valid),
        .out_data  (rr_out_data),
        .out_sel   (rr_out_sel),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.NCH(4), .W(8), .MODE(MODE_FIXED)) dut_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fx_valid),
        .in_data   (in_data),
        .in_ready  (fx_in_ready),
        .out_valid (fx_out_valid),
        .out_data  (fx_out_data),
        .out_sel   (fx_out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] onehot(input int n);
        logic [3:0] v;
        v = 4'b0001;
        return v << n;
    endfunction

    // Present rr_valid, check in_ready, clock, check the loaded beat
    task automatic rr_beat(input string tag, input logic [3:0] v, input int ch, input logic [7:0] dat);
        rr_valid = v;
        #1;
        chk({tag, "_rdy"}, {28'd0, rr_in_ready}, {28'd0, onehot(ch)});
        tick();
        chk({tag, "_sel"}, {30'd0, rr_out_sel}, ch);
        chk({tag, "_dat"}, {24'd0, rr_out_data}, {24'd0, dat});
        chk({tag, "_vld"}, {31'd0, rr_out_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        rr_valid  = 4'b0000;
        fx_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Reset state
        #12;
        chk("rst_rr_vld", {31'd0, rr_out_valid}, 32'd0);
        chk("rst_rr_dat", {24'd0, rr_out_data}, 32'd0);
        chk("rst_rr_sel", {30'd0, rr_out_sel}, 32'd0);
        chk("rst_fx_vld", {31'd0, fx_out_valid}, 32'd0);
        fx_valid = 4'b1111;
        #1;
        chk("rst_fx_rdy", {28'd0, fx_in_ready}, 32'd0);
        fx_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Fixed priority: 1010 always grants ch1
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fx_valid = 4'b1010;
            #1;
            chk("fx_rdy", {28'd0, fx_in_ready}, 32'h2);
            chk("fx_rr_idle", {28'd0, rr_in_ready}, 32'h0);
            tick();
            chk("fx_sel", {30'd0, fx_out_sel}, 32'd1);
            chk("fx_dat", {24'd0, fx_out_data}, 32'hA1);
            chk("fx_vld", {31'd0, fx_out_valid}, 32'd1);
        end
        // Drain with no new input: valid clears, data/sel hold
        fx_valid = 4'b0000;
        #1;
        chk("fx_idle_rdy", {28'd0, fx_in_ready}, 32'h0);
        tick();
        chk("fx_drain_vld", {31'd0, fx_out_valid}, 32'd0);
        chk("fx_drain_sel", {30'd0, fx_out_sel}, 32'd1);
        chk("fx_drain_dat", {24'd0, fx_out_data}, 32'hA1);

        // Round-robin fairness from ptr=0, no bubbles
        for (int i = 0; i < 5; i++) begin
            rr_beat("rr_fair", 4'b1111, i % 4, 8'hA0 + 8'(i % 4));
        end
        rr_valid = 4'b0000;
        tick();
        chk("rr_drain_vld", {31'd0, rr_out_valid}, 32'd0);

        // Backpressure: ch2 beat 5C held while out_ready=0 (ptr=1 -> grant ch2, ptr becomes 3)
        in_data[23:16] = 8'h5C;
        rr_beat("bp_load", 4'b0100, 2, 8'h5C);
        out_ready = 1'b0;
        rr_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_rdy", {28'd0, rr_in_ready}, 32'h0);
            tick();
            chk("bp_dat", {24'd0, rr_out_data}, 32'h5C);
            chk("bp_sel", {30'd0, rr_out_sel}, 32'd2);
            chk("bp_vld", {31'd0, rr_out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        in_data[23:16] = 8'hA2;
        // ptr=3 so the released slot goes to ch3, loaded on the next edge
        rr_beat("bp_release", 4'b1111, 3, 8'hA3);

        // Pointer wrap and skip: ptr=0 -> ch2 sets ptr=3; 0001 wraps to ch0 (ptr=1)
        rr_beat("wrap_pre", 4'b0100, 2, 8'hA2);
        rr_beat("wrap_ch0", 4'b0001, 0, 8'hA0);
        // ptr=1: ch0 is valid but skipped, ch2 wins
        rr_beat("wrap_skip", 4'b0101, 2, 8'hA2);

        // Reset mid-operation with a held beat
        rr_valid  = 4'b0000;
        out_ready = 1'b0;
        tick();
        chk("mid_pre_vld", {31'd0, rr_out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, rr_out_valid}, 32'd0);
        chk("mid_rst_dat", {24'd0, rr_out_data}, 32'd0);
        chk("mid_rst_sel", {30'd0, rr_out_sel}, 32'd0);
        rr_valid = 4'b1111;
        #1;
        chk("mid_rst_rdy", {28'd0, rr_in_ready}, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        // First grant after release follows ptr=0
        rr_beat("post_rst", 4'b1111, 0, 8'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
